// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_pkg                                                       |
// | Purpose  : Shared constants for the SPI slave: default frame width,      |
// |            IDLE/ACTIVE state encoding and the minimum m_clk:spi_clk      |
// |            ratio the design relies on.                                   |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package spi_pkg;

    localparam int         c_data_w_default = 8;
    localparam int         c_min_clk_ratio  = 4;

    localparam int         c_state_w        = 1;
    localparam logic [0:0] c_st_idle        = 1'b0;
    localparam logic [0:0] c_st_active      = 1'b1;

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_sync                                                      |
// | Purpose  : Two-flop synchronizer for one asynchronous input plus edge    |
// |            detection of the synchronized value against its previous      |
// |            value.                                                        |
// | Ports    : clk     - system clock (rising edge)                          |
// |            rst_n   - asynchronous active-low reset, clears all flops     |
// |            i_async - asynchronous input                                  |
// |            o_sync  - synchronized value                                  |
// |            o_rise  - one-cycle strobe, synchronized value went 0->1      |
// |            o_fall  - one-cycle strobe, synchronized value went 1->0      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spi_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_slave                                                     |
// | Purpose  : SPI mode-0 slave, oversampled by m_clk (>= 4x spi_clk).       |
// |            One transmit holding buffer, receive without back-pressure,   |
// |            back-to-back frames within one chip-select period.            |
// | Ports    : m_clk    - system clock          nrst     - async reset, low  |
// |            spi_clk  - serial clock (idle 0) spi_cs   - chip select, low  |
// |            spi_mosi - serial data in        spi_miso - serial data out   |
// |            tx_data  - word to transmit      tx_load  - tx_data strobe    |
// |            tx_ready - holding buffer empty  rx_data  - last full word    |
// |            rx_valid - 1-cycle new rx_data   busy     - frame in progress |
// | Config   : SPI_SLAVE_LSB_FIRST_EN - shift rx and tx LSB first            |
// |            (default: MSB first)                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W = c_data_w_default
) (
    input  logic              m_clk,
    input  logic              nrst,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int                c_cnt_w = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_W - 1);

    // Bit 0: spi_clk, bit 1: spi_cs, bit 2: spi_mosi
    logic [2:0] w_async;
    logic [2:0] w_sync;
    logic [2:0] w_rise;
    logic [2:0] w_fall;

    assign w_async = {spi_mosi, spi_cs, spi_clk};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        spi_sync u_sync (
            .clk     (m_clk),
            .rst_n   (nrst),
            .i_async (w_async[gi]),
            .o_sync  (w_sync[gi]),
            .o_rise  (w_rise[gi]),
            .o_fall  (w_fall[gi])
        );
    end

    logic w_clk_rise;
    logic w_clk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi_s;
    logic w_unused;

    assign w_clk_rise = w_rise[0];
    assign w_clk_fall = w_fall[0];
    assign w_cs_rise  = w_rise[1];
    assign w_cs_fall  = w_fall[1];
    assign w_mosi_s   = w_sync[2];
    assign w_unused   = ^{w_sync[1:0], w_rise[2], w_fall[2]};

    logic [c_state_w-1:0] r_state;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]    r_rx_shift;
    logic [DATA_W-1:0]    r_tx_shift;
    logic [DATA_W-1:0]    r_hold;
    logic                 r_tx_ready;
    logic [DATA_W-1:0]    r_rx_data;
    logic                 r_rx_valid;

    logic [DATA_W-1:0]    w_rx_next;
    logic [DATA_W-1:0]    w_tx_shifted;
    logic [DATA_W-1:0]    w_reload_word;
    logic                 w_load_ok;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam int c_out_bit = 0;
    assign w_rx_next    = {w_mosi_s, r_rx_shift[DATA_W-1:1]};
    assign w_tx_shifted = {1'b0, r_tx_shift[DATA_W-1:1]};
`else
    localparam int c_out_bit = DATA_W - 1;
    assign w_rx_next    = {r_rx_shift[DATA_W-2:0], w_mosi_s};
    assign w_tx_shifted = {r_tx_shift[DATA_W-2:0], 1'b0};
`endif

    assign w_load_ok = tx_load & r_tx_ready;

    // Word entering the shifter: a load arriving on the reload cycle goes
    // straight through; otherwise the buffer content, or zeros on underrun.
    assign w_reload_word = r_tx_ready ? (tx_load ? tx_data : '0) : r_hold;

    always_ff @(posedge m_clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= c_st_idle;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_hold     <= '0;
            r_tx_ready <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;

            if (w_load_ok) begin
                r_hold     <= tx_data;
                r_tx_ready <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_cs_fall) begin
                        r_state    <= c_st_active;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                        r_tx_shift <= w_reload_word;
                        r_tx_ready <= 1'b1;
                    end
                end
                c_st_active: begin
                    if (w_cs_rise) begin
                        // Partial word is dropped; holding buffer is kept.
                        r_state    <= c_st_idle;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                        r_tx_shift <= '0;
                    end else begin
                        if (w_clk_rise) begin
                            r_rx_shift <= w_rx_next;
                            if (r_bit_cnt == c_last) begin
                                r_bit_cnt  <= '0;
                                r_rx_data  <= w_rx_next;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                            end
                        end
                        // A falling edge with the counter at 0 can only follow
                        // a completed word, since spi_clk idles low.
                        if (w_clk_fall) begin
                            if (r_bit_cnt == '0) begin
                                r_tx_shift <= w_reload_word;
                                r_tx_ready <= 1'b1;
                            end else begin
                                r_tx_shift <= w_tx_shifted;
                            end
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Gated by the raw pin so the line is 0 the moment the slave is deselected.
    assign spi_miso = r_tx_shift[c_out_bit] & ~spi_cs;
    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state == c_st_active);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spi_slave                                                  |
// | Purpose  : Self-checking bench for spi_slave. A mode-0 master model      |
// |            drives frames (m_clk 100 ns, spi_clk 800 ns); a reference     |
// |            model of the one-deep holding buffer predicts the words seen  |
// |            on MISO, and a monitor pops expected receive words on each    |
// |            rx_valid. Honours SPI_SLAVE_LSB_FIRST_EN for bit order.       |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_spi_slave;
    import spi_pkg::*;

    localparam int W = c_data_w_default;

    logic         m_clk = 1'b0;
    logic         nrst;
    logic         spi_clk;
    logic         spi_cs;
    logic         spi_mosi;
    logic         spi_miso;
    logic [W-1:0] tx_data;
    logic         tx_load;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic         m_full;
    logic [W-1:0] m_hold;
    logic [W-1:0] m_last_rx;
    logic [W-1:0] exp_rx_q[$];
    logic [W-1:0] exp_tx_q[$];

    // Current frame description
    logic [W-1:0] f_words[$];
    bit           f_coinc[$];
    logic [W-1:0] f_cdata[$];

    spi_slave #(.DATA_W(W)) dut (
        .m_clk    (m_clk),
        .nrst     (nrst),
        .spi_clk  (spi_clk),
        .spi_cs   (spi_cs),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #50 m_clk = ~m_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Wire position of bit b of a word (b = 0 is first on the wire)
    function automatic int wire_pos(input int b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return b;
`else
        return W - 1 - b;
`endif
    endfunction

    function automatic bit coinc_at(input int w);
        return (w < f_coinc.size()) ? f_coinc[w] : 1'b0;
    endfunction

    function automatic logic [W-1:0] cdata_at(input int w);
        return (w < f_cdata.size()) ? f_cdata[w] : '0;
    endfunction

    // Holding buffer model: one slot, loads accepted only when empty
    task automatic model_load(input logic [W-1:0] d);
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = d;
        end
    endtask

    // A word starts on the wire: buffer content, a coincident load into an
    // empty buffer, or zeros.
    task automatic model_take(input bit coinc, input logic [W-1:0] cdata, output logic [W-1:0] word);
        if (m_full)     word = m_hold;
        else if (coinc) word = cdata;
        else            word = '0;
        m_full = 1'b0;
    endtask

    task automatic spi_half();
        repeat (4) @(posedge m_clk);
        #20;
    endtask

    task automatic tb_load(input logic [W-1:0] d);
        @(negedge m_clk);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge m_clk);
        tx_load = 1'b0;
        model_load(d);
        check("tx_ready_after_load", tx_ready, !m_full);
    endtask

    task automatic rx_monitor();
        forever begin
            @(negedge m_clk);
            if (nrst === 1'b1 && rx_valid === 1'b1) begin
                if (exp_rx_q.size() == 0) check("rx_unexpected_pulse", rx_valid, 1'b0);
                else                      check("rx_data", rx_data, exp_rx_q.pop_front());
            end
        end
    endtask

    task automatic run_frame(input int nbits, input bit do_rst);
        logic [W-1:0] word;
        logic [W-1:0] obs;
        bit           cn;
        int           w;
        int           b;
        @(posedge m_clk);
        #20;
        spi_cs = 1'b0;
        model_take(1'b0, '0, word);
        exp_tx_q.push_back(word);
        obs = '0;
        for (int k = 0; k < nbits; k++) begin
            w = k / W;
            b = k % W;
            spi_mosi = f_words[w][wire_pos(b)];
            if (b == 0 && w > 0 && coinc_at(w)) begin
                // Load lands on the m_clk edge that reloads the shifter
                repeat (2) @(posedge m_clk);
                @(negedge m_clk);
                tx_data = f_cdata[w];
                tx_load = 1'b1;
                @(posedge m_clk);
                @(negedge m_clk);
                tx_load = 1'b0;
                @(posedge m_clk);
                #20;
            end else begin
                spi_half();
            end
            spi_clk = 1'b1;
            obs[wire_pos(b)] = spi_miso;
            if (k == 0) check("busy_active", busy, 1'b1);
            if (b == W - 1) begin
                exp_rx_q.push_back(f_words[w]);
                m_last_rx = f_words[w];
                repeat (2) @(posedge m_clk);
                #1 check("rx_valid_early", rx_valid, 1'b0);
                @(posedge m_clk);
                #1 check("rx_valid_latency", rx_valid, 1'b1);
                @(posedge m_clk);
                #20;
            end else begin
                spi_half();
            end
            spi_clk = 1'b0;
            if (b == W - 1) begin
                if (exp_tx_q.size() == 0) check("miso_word_missing_expect", obs, ~obs);
                else                      check("miso_word", obs, exp_tx_q.pop_front());
                obs = '0;
                cn = (k + 1 < nbits) && coinc_at(w + 1);
                model_take(cn, cdata_at(w + 1), word);
                if (k + 1 < nbits) exp_tx_q.push_back(word);
            end
        end
        spi_half();
        if (do_rst) begin
            tb_load(8'h5A);
            nrst = 1'b0;
            #1;
            check("rst_miso", spi_miso, 1'b0);
            check("rst_tx_ready", tx_ready, 1'b1);
            check("rst_rx_data", rx_data, '0);
            check("rst_rx_valid", rx_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            m_full    = 1'b0;
            m_last_rx = '0;
            exp_rx_q.delete();
            repeat (3) @(posedge m_clk);
            @(negedge m_clk);
            nrst = 1'b1;
            repeat (10) @(posedge m_clk);
            #1 check("no_frame_without_cs_edge", busy, 1'b0);
        end
        spi_cs = 1'b1;
        exp_tx_q.delete();
        spi_half();
        spi_half();
        check("busy_idle", busy, 1'b0);
        check("miso_deselected", spi_miso, 1'b0);
        check("rx_pending", exp_rx_q.size(), 0);
        check("rx_data_held", rx_data, m_last_rx);
        check("tx_ready_frame_end", tx_ready, !m_full);
    endtask

    initial begin
        int nw;
        int nbits;
        nrst      = 1'b0;
        spi_clk   = 1'b0;
        spi_cs    = 1'b1;
        spi_mosi  = 1'b0;
        tx_load   = 1'b0;
        tx_data   = '0;
        m_full    = 1'b0;
        m_hold    = '0;
        m_last_rx = '0;
        repeat (3) @(posedge m_clk);
        #1;
        check("reset_rx_data", rx_data, '0);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_tx_ready", tx_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_miso", spi_miso, 1'b0);
        @(negedge m_clk);
        nrst = 1'b1;
        fork
            rx_monitor();
        join_none
        repeat (5) @(posedge m_clk);

`ifdef SPI_SLAVE_LSB_FIRST_EN
        // Wire sequence 1,0,0,0,0,0,0,0
        f_words = '{8'h01};
        f_coinc.delete();
        run_frame(W, 1'b0);
        check("lsb_first_rx", rx_data, 8'h01);
`endif

        // Single frame, master sends 0xA5, slave answers 0x3C
        tb_load(8'h3C);
        f_words = '{8'hA5};
        f_coinc.delete();
        run_frame(W, 1'b0);
        check("frame_a5_rx", rx_data, 8'hA5);

        // Back-to-back words with one word loaded: 0x55 then underrun
        tb_load(8'h55);
        f_words = '{8'h12, 8'h34};
        run_frame(2 * W, 1'b0);

        // Aborted after 5 bits, then a full 0xFF frame
        f_words = '{8'hC3};
        run_frame(5, 1'b0);
        f_words = '{8'hFF};
        run_frame(W, 1'b0);

        // Second load while full is dropped
        tb_load(8'h11);
        tb_load(8'h22);
        f_words = '{8'h6B};
        run_frame(W, 1'b0);

        // Load coinciding with the word-boundary reload
        f_words = '{8'h0F, 8'hE1};
        f_coinc = '{1'b0, 1'b1};
        f_cdata = '{8'h00, 8'h96};
        run_frame(2 * W, 1'b0);
        f_coinc.delete();

        // Reset mid-word, then 0x81
        f_words = '{8'h7E};
        run_frame(4, 1'b1);
        f_words = '{8'h81};
        run_frame(W, 1'b0);
        check("frame_81_rx", rx_data, 8'h81);

        // Randomized frames
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) tb_load(W'($urandom));
            if ($urandom_range(0, 3) == 0) tb_load(W'($urandom));
            nw = $urandom_range(1, 3);
            f_words.delete();
            f_coinc.delete();
            f_cdata.delete();
            for (int j = 0; j < nw; j++) begin
                f_words.push_back(W'($urandom));
                f_coinc.push_back($urandom_range(0, 2) == 0);
                f_cdata.push_back(W'($urandom));
            end
            nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nw * W - 1) : nw * W;
            run_frame(nbits, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
